// File: rtl/contador_pc_pila_if.sv
// rtl/contador_pc_pila_if.sv - control and status bundle between control unit and program counter
interface contador_pc_pila_if #(
   parameter int AW    = 5,
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH + 1);

   logic          en;
   logic [2:0]    op;
   logic [AW-1:0] IN;
   logic [AW-1:0] OFS;
   logic          clr_err;

   logic [AW-1:0] OUT;
   logic [LW-1:0] level;
   logic          full;
   logic          empty;
   logic          wrap;
   logic          ovf;
   logic          unf;

   // Control unit side: issues operations, observes address and stack status.
   modport master (
      output en, op, IN, OFS, clr_err,
      input  OUT, level, full, empty, wrap, ovf, unf
   );

   // Program counter side.
   modport slave (
      input  en, op, IN, OFS, clr_err,
      output OUT, level, full, empty, wrap, ovf, unf
   );
endinterface

// File: rtl/contador_pc_pila.sv
// rtl/contador_pc_pila.sv - program counter with jump, relative branch, call/return stack and error flags
module contador_pc_pila #(
   parameter int            AW       = 5,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] RST_ADDR = '0
) (
   input logic               CLK,
   input logic               rst_n,
   contador_pc_pila_if.slave bus
);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [2:0] OP_INC    = 3'b000;
   localparam logic [2:0] OP_JUMP   = 3'b001;
   localparam logic [2:0] OP_BRANCH = 3'b010;
   localparam logic [2:0] OP_CALL   = 3'b011;
   localparam logic [2:0] OP_RET    = 3'b100;

   logic [AW-1:0] out_q,   out_d;
   logic [LW-1:0] level_q, level_d;
   logic [AW-1:0] stack_q [DEPTH];
   logic [AW-1:0] stack_d [DEPTH];
   logic          wrap_q,  wrap_d;
   logic          ovf_q,   ovf_d;
   logic          unf_q,   unf_d;

   logic          full_w;
   logic          empty_w;
   logic [IW-1:0] push_idx;
   logic [IW-1:0] pop_idx;
   logic [AW:0]   inc_sum;
   logic [AW:0]   br_sum;

   assign full_w   = (level_q == LW'(DEPTH));
   assign empty_w  = (level_q == '0);
   // Level is the stack pointer: next free slot on push, one above the top on pop.
   assign push_idx = IW'(level_q);
   assign pop_idx  = IW'(level_q - LW'(1));
   // Extra MSB carries out of the address width to detect wrap-around.
   assign inc_sum  = {1'b0, out_q} + (AW+1)'(1);
   assign br_sum   = {1'b0, out_q} + {1'b0, bus.OFS};

   // Next-state decode of address, stack and flags from the sampled operation.
   always_comb begin
      out_d   = out_q;
      level_d = level_q;
      stack_d = stack_q;
      wrap_d  = 1'b0;
      ovf_d   = ovf_q & ~bus.clr_err;
      unf_d   = unf_q & ~bus.clr_err;
      if (bus.en) begin
         case (bus.op)
            OP_INC: begin
               out_d  = inc_sum[AW-1:0];
               wrap_d = inc_sum[AW];
            end
            OP_JUMP: begin
               out_d = bus.IN;
            end
            OP_BRANCH: begin
               out_d  = br_sum[AW-1:0];
               // Positive offset wraps on carry; negative offset wraps when no carry (borrow).
               wrap_d = br_sum[AW] ^ bus.OFS[AW-1];
            end
            OP_CALL: begin
               if (full_w) begin
                  ovf_d = 1'b1;
               end else begin
                  stack_d[push_idx] = inc_sum[AW-1:0];
                  level_d           = level_q + LW'(1);
                  out_d             = bus.IN;
               end
            end
            OP_RET: begin
               if (empty_w) begin
                  unf_d = 1'b1;
               end else begin
                  out_d   = stack_q[pop_idx];
                  level_d = level_q - LW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // State registers with asynchronous reset that empties the stack.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= RST_ADDR;
         level_q <= '0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= '0;
         end
      end else begin
         out_q   <= out_d;
         level_q <= level_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= stack_d[i];
         end
      end
   end

   assign bus.OUT   = out_q;
   assign bus.level = level_q;
   assign bus.full  = full_w;
   assign bus.empty = empty_w;
   assign bus.wrap  = wrap_q;
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;
endmodule
